// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension stage.
// Mode codes match the 2-bit in_mode field.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SEXT   = 2'b00,
    MODE_ZEXT   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper and branch forms.
// Branch form is the sign-extended value shifted left by BR_SHIFT.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  mode_e            mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = OUT_W'(imm);
  assign sext = zext | ({OUT_W{imm[IN_W-1]}} << IN_W);

  always_comb begin
    ext = zext;
    unique case (mode)
      MODE_SEXT:   ext = sext;
      MODE_ZEXT:   ext = zext;
      MODE_UPPER:  ext = zext << (OUT_W - IN_W);
      MODE_BRANCH: ext = sext << BR_SHIFT;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer.
// in_ready is the inverted skid-valid flop, so it never depends on out_ready.
module imm_extend_stage
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg
);

  logic [OUT_W-1:0] ext;
  logic             sk_v;
  logic [OUT_W-1:0] sk_imm;
  logic [TAG_W-1:0] sk_tag;
  logic             in_fire;
  logic             drain;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_core (
    .imm (in_imm),
    .mode(mode_e'(in_mode)),
    .ext (ext)
  );

  assign in_ready = !sk_v;
  assign in_fire  = in_valid && in_ready;
  assign drain    = !out_valid || out_ready;
  assign out_neg  = out_imm[OUT_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      sk_v      <= 1'b0;
      sk_imm    <= '0;
      sk_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sk_v      <= 1'b0;
    end else if (drain) begin
      if (sk_v) begin
        out_valid <= 1'b1;
        out_imm   <= sk_imm;
        out_tag   <= sk_tag;
        sk_v      <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) begin
          out_imm <= ext;
          out_tag <= in_tag;
        end
      end
    end else if (in_fire) begin
      // Output is stalled: park the new entry behind it.
      sk_v   <= 1'b1;
      sk_imm <= ext;
      sk_tag <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench for imm_extend_stage with a behavioural reference model.
// Observer pushes on input transfers; monitor pops on output transfers.
module tb_imm_extend_stage;

  localparam int IN_W = 16;
  localparam int OUT_W = 32;
  localparam int BR_SHIFT = 2;
  localparam int TAG_W = 5;

  typedef struct {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm = '0;
  logic [1:0]       in_mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_neg;

  int tests = 0;
  int fails = 0;
  int pops = 0;
  exp_t q[$];
  logic [TAG_W-1:0] seen_tags[$];

  imm_extend_stage #(
    .IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_tag(out_tag), .out_neg(out_neg)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] model(logic [IN_W-1:0] imm,
                                             logic [1:0] mode);
    longint v;
    longint r;
    v = longint'(imm);
    if (v >= (longint'(1) << (IN_W - 1))) v = v - (longint'(1) << IN_W);
    case (mode)
      2'd0:    r = v;
      2'd1:    r = longint'(imm);
      2'd2:    r = longint'(imm) * (longint'(1) << (OUT_W - IN_W));
      default: r = v * (longint'(1) << BR_SHIFT);
    endcase
    return r[OUT_W-1:0];
  endfunction

  task automatic check(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input-side observer.
  always @(negedge clk) begin
    if (!reset && !flush && in_valid && in_ready)
      q.push_back('{model(in_imm, in_mode), in_tag});
  end

  // Output-side monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        pops++;
        seen_tags.push_back(out_tag);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got tag %0h imm %0h, expected none",
                   out_tag, out_imm);
        end else begin
          e = q.pop_front();
          check("sb_imm", out_imm, e.imm);
          check("sb_tag", out_tag, e.tag);
          check("sb_neg", out_neg, e.imm[OUT_W-1]);
        end
      end
      if (flush) q.delete();
    end
  end

  task automatic offer(logic [IN_W-1:0] imm, logic [1:0] mode,
                       logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_tag   = tag;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while ((q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", n < budget, 1);
  endtask

  typedef struct {
    logic [IN_W-1:0]  imm;
    logic [1:0]       mode;
    logic [OUT_W-1:0] res;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h8001, 2'd0, 32'hFFFF8001};
    vecs[1] = '{16'h8001, 2'd1, 32'h00008001};
    vecs[2] = '{16'h1234, 2'd2, 32'h12340000};
    vecs[3] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
    vecs[4] = '{16'h0003, 2'd3, 32'h0000000C};

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_neg", out_neg, 0);
    reset = 1'b0;
    tick();

    // Mode sweep: each result one cycle after acceptance.
    foreach (vecs[i]) begin
      offer(vecs[i].imm, vecs[i].mode, TAG_W'(i + 1));
      tick();
      in_valid = 1'b0;
      check("sweep_valid", out_valid, 1);
      check("sweep_imm", out_imm, vecs[i].res);
      check("sweep_neg", out_neg, vecs[i].res[OUT_W-1]);
      tick();
    end
    drain(10);

    // Backpressure: tags 1,2 accepted, 3 held.
    out_ready = 1'b0;
    seen_tags.delete();
    offer(16'h0011, 2'd0, 5'd1);
    tick();
    check("bp_ready_after_1", in_ready, 1);
    offer(16'h0022, 2'd1, 5'd2);
    tick();
    check("bp_ready_after_2", in_ready, 0);
    offer(16'h0033, 2'd2, 5'd3);
    tick();
    check("bp_hold_tag", out_tag, 1);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_tag2_next", out_tag, 2);
    check("bp_ready_back", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_tag3_next", out_tag, 3);
    drain(10);
    check("bp_count", seen_tags.size(), 3);
    if (seen_tags.size() == 3) begin
      check("bp_order0", seen_tags[0], 1);
      check("bp_order1", seen_tags[1], 2);
      check("bp_order2", seen_tags[2], 3);
    end

    // Streaming: 20 back-to-back.
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      offer(IN_W'($urandom), 2'($urandom_range(0, 3)), TAG_W'(i));
      check("stream_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("stream_count", pops, 20);
    drain(10);

    // Flush with both entries full plus a new offer.
    out_ready = 1'b0;
    offer(16'hAAAA, 2'd0, 5'd10);
    tick();
    offer(16'hBBBB, 2'd1, 5'd11);
    tick();
    check("fl_full", in_ready, 0);
    offer(16'hCCCC, 2'd2, 5'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    pops = 0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("fl_none_out", pops, 0);

    // Async reset mid-cycle with both entries full.
    out_ready = 1'b0;
    offer(16'h8123, 2'd0, 5'd20);
    tick();
    offer(16'h4567, 2'd3, 5'd21);
    tick();
    in_valid = 1'b0;
    check("ar_out_valid_pre", out_valid, 1);
    check("ar_full_pre", in_ready, 0);
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_out_imm", out_imm, 0);
    check("ar_out_tag", out_tag, 0);
    check("ar_out_neg", out_neg, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    offer(16'hF00D, 2'd3, 5'd22);
    tick();
    in_valid = 1'b0;
    check("ar_first_valid", out_valid, 1);
    check("ar_first_imm", out_imm, model(16'hF00D, 2'd3));
    check("ar_first_tag", out_tag, 22);
    drain(10);

    // Random traffic with random backpressure and rare flushes.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_imm    = IN_W'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = TAG_W'($urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;
    drain(20);
    check("final_q_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Parametrised, registered immediate-extension stage for the pipelined CPU's decode→execute path.
- Extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes:
  - sign-extend
  - zero-extend
  - upper (place in high bits)
  - branch (sign-extend, then shift left by BR_SHIFT)
- Valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and full throughput holds under backpressure.
- Supports pipeline flush for mispredicted branches.

Parameters:
- IN_W, 16, immediate input width; must be ≥2.
- OUT_W, 32, extended output width; must be ≥ IN_W + BR_SHIFT.
- BR_SHIFT, 2, left shift applied in branch mode (word→byte offset).
- TAG_W, 5, width of sideband tag carried alongside the immediate (e.g. destination register).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; discard all buffered entries
- in_valid  input  1  upstream offers an immediate
- in_ready  output  1  stage can accept (registered)
- in_imm  input  IN_W  raw immediate field
- in_mode  input  2  00 SEXT, 01 ZEXT, 10 UPPER, 11 BRANCH
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  out_imm/out_tag/out_neg are valid
- out_ready  input  1  downstream accepts
- out_imm  output  OUT_W  extended immediate
- out_tag  output  TAG_W  tag matching out_imm
- out_neg  output  1  MSB of out_imm

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_neg=0. Skid entry is empty.
- Extension rules (combinational, applied before capture):
  - SEXT: replicate in_imm[IN_W-1] into bits [OUT_W-1:IN_W].
  - ZEXT: zeros in bits [OUT_W-1:IN_W].
  - UPPER: in_imm occupies [OUT_W-1:OUT_W-IN_W]; lower OUT_W-IN_W bits are zero. If OUT_W < 2*IN_W, the low bits are still zero and in_imm fills from the MSB.
  - BRANCH: SEXT result shifted left by BR_SHIFT, zeros shifted in. No bits are lost, per the parameter constraint.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle: data accepted at edge N appears on out_* after edge N when the output register is empty or draining.
  - Throughput is 1 per cycle while out_ready=1.
- Buffer: output register plus one skid register.
  - If the output register holds data and out_ready=0 while an input transfer occurs, the input goes to the skid register. in_ready deasserts at the next edge.
  - When the output drains and the skid is full, skid moves to the output register. in_ready reasserts at the same edge.
  - Order is strictly FIFO. No entry is dropped or duplicated.
- Simultaneous input and output transfer with skid empty: the output register loads the new data; out_valid stays 1.
- Holding: out_* remain stable while out_valid=1 and out_ready=0.
- Flush:
  - At the next edge, both entries are invalidated: out_valid=0, in_ready=1.
  - An input offered in the flush cycle is discarded.
  - An output transfer coinciding with flush counts as completed.
  - out_imm/out_tag hold their values, which are don't-care.
- Reset mid-operation: immediate return to reset values, regardless of clock.
- Invalid mode values: none; all 4 codes are defined.
- in_valid may assert regardless of in_ready. Data is captured only on a transfer.

Decomposition:
- Package imm_ext_pkg:
  - mode constants MODE_SEXT=2'b00, MODE_ZEXT=2'b01, MODE_UPPER=2'b10, MODE_BRANCH=2'b11
  - mode type
- One combinational sub-module, imm_ext_core (IN_W, OUT_W, BR_SHIFT; imm, mode → ext). Instantiated once ahead of the skid logic, which lives in imm_extend_stage.

Test Plan:
- Defaults used throughout: IN_W=16, OUT_W=32, BR_SHIFT=2, out_ready=1.
- Mode sweep with in_imm=0x8001:
  - SEXT→0xFFFF8001, out_neg=1
  - ZEXT→0x00008001, out_neg=0
  - UPPER with 0x1234→0x12340000
  - BRANCH with 0xFFFF→0xFFFFFFFC
  - BRANCH with 0x0003→0x0000000C
  - Each appears one cycle after acceptance.
- Backpressure: out_ready=0 for 3 cycles; in_valid=1 with tags 1,2,3 → tags 1 and 2 accepted, in_ready=0 after the second, tag 3 held. Then out_ready=1 → outputs tag 1,2,3 in order on consecutive cycles, none lost.
- Streaming: 20 back-to-back inputs with out_ready=1 → 20 outputs, 1 per cycle, in_ready constantly 1.
- Flush with both entries full, plus a new input in the same cycle → next cycle out_valid=0, in_ready=1; none of the three items is ever output.
- Async reset asserted mid-clock while out_valid=1 and skid full → outputs go to reset values immediately, without a clock edge; first input after release is output correctly.
